// File: rtl/blinker_nios2_proc_oci_dct_pkg.sv
// rtl/blinker_nios2_proc_oci_dct_pkg.sv - shared widths and state type for the DCT packer
package blinker_nios2_proc_oci_dct_pkg;
   localparam int SLOT_W = 2;
   localparam int SLOTS  = 15;
   localparam int BUF_W  = SLOT_W * SLOTS;
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

   typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;
endpackage

// File: rtl/blinker_nios2_proc_oci_dct_packer_if.sv
// rtl/blinker_nios2_proc_oci_dct_packer_if.sv - code input, DCT output and end-of-test signals
interface blinker_nios2_proc_oci_dct_packer_if;
   import blinker_nios2_proc_oci_dct_pkg::*;

   logic              code_valid;
   logic [SLOT_W-1:0] code_data;
   logic              code_ready;
   logic              trace_end;
   logic              dct_valid;
   logic              dct_ready;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_ending;
   logic              test_has_ended;

   modport master (
      input  code_valid, code_data, trace_end, dct_ready,
      output code_ready, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended
   );

   modport slave (
      output code_valid, code_data, trace_end, dct_ready,
      input  code_ready, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended
   );
endinterface

// File: rtl/blinker_nios2_proc_oci_dct_hold.sv
// rtl/blinker_nios2_proc_oci_dct_hold.sv - output holding register for packed DCT buffers
module blinker_nios2_proc_oci_dct_hold
   import blinker_nios2_proc_oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BUF_W-1:0] buf_in,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             dct_ready,
   output logic             dct_valid,
   output logic [BUF_W-1:0] dct_buffer,
   output logic [CNT_W-1:0] dct_count,
   output logic             slot_free
);
   logic             dct_valid_q, dct_valid_d;
   logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
   logic [CNT_W-1:0] dct_count_q, dct_count_d;

   always_comb begin
      dct_valid_d  = dct_valid_q && !dct_ready;
      dct_buffer_d = dct_buffer_q;
      dct_count_d  = dct_count_q;
      if (load) begin
         dct_valid_d  = 1'b1;
         dct_buffer_d = buf_in;
         dct_count_d  = cnt_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dct_valid_q  <= 1'b0;
         dct_buffer_q <= '0;
         dct_count_q  <= '0;
      end else begin
         dct_valid_q  <= dct_valid_d;
         dct_buffer_q <= dct_buffer_d;
         dct_count_q  <= dct_count_d;
      end
   end

   assign dct_valid  = dct_valid_q;
   assign dct_buffer = dct_buffer_q;
   assign dct_count  = dct_count_q;
   assign slot_free  = !dct_valid_q || dct_ready;
endmodule

// File: rtl/blinker_nios2_proc_oci_dct_packer.sv
// rtl/blinker_nios2_proc_oci_dct_packer.sv - packs 2-bit trace codes into 15-slot DCT buffers
module blinker_nios2_proc_oci_dct_packer
   import blinker_nios2_proc_oci_dct_pkg::*;
(
   input logic clk,
   input logic reset,
   blinker_nios2_proc_oci_dct_packer_if.master bus
);
   state_t           state_q, state_d;
   logic [BUF_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             code_ready_q, code_ready_d;
   logic             test_ending_q, test_ending_d;
   logic             test_has_ended_q, test_has_ended_d;
   logic             accept, load, slot_free;

   always_comb begin
      accept = bus.code_valid && code_ready_q;
      // Accept and load never coincide: a full count or DRAIN both hold code_ready low.
      load   = slot_free && (acc_cnt_q != '0) &&
               ((acc_cnt_q == FULL_CNT) || (state_q == DRAIN));
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      if (load) begin
         acc_d     = '0;
         acc_cnt_d = '0;
      end else if (accept) begin
         acc_d     = acc_q | (BUF_W'(bus.code_data) << (SLOT_W * int'(acc_cnt_q)));
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end

      state_d = state_q;
      case (state_q)
         RUN:     if (bus.trace_end) state_d = DRAIN;
         DRAIN:   if ((acc_cnt_q == '0) && slot_free) state_d = ENDED;
         default: state_d = state_q;
      endcase

      // Registered copies of functions of the next state, so they read 0 during reset.
      code_ready_d     = (state_d == RUN) && (acc_cnt_d != FULL_CNT);
      test_ending_d    = (state_d == DRAIN);
      test_has_ended_d = (state_d == ENDED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= RUN;
         acc_q            <= '0;
         acc_cnt_q        <= '0;
         code_ready_q     <= 1'b0;
         test_ending_q    <= 1'b0;
         test_has_ended_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         acc_q            <= acc_d;
         acc_cnt_q        <= acc_cnt_d;
         code_ready_q     <= code_ready_d;
         test_ending_q    <= test_ending_d;
         test_has_ended_q <= test_has_ended_d;
      end
   end

   blinker_nios2_proc_oci_dct_hold u_hold (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .buf_in     (acc_q),
      .cnt_in     (acc_cnt_q),
      .dct_ready  (bus.dct_ready),
      .dct_valid  (bus.dct_valid),
      .dct_buffer (bus.dct_buffer),
      .dct_count  (bus.dct_count),
      .slot_free  (slot_free)
   );

   assign bus.code_ready     = code_ready_q;
   assign bus.test_ending    = test_ending_q;
   assign bus.test_has_ended = test_has_ended_q;
endmodule

// File: tb/tb_blinker_nios2_proc_oci_dct_packer.sv
// tb/tb_blinker_nios2_proc_oci_dct_packer.sv - randomized and directed checks against a queue model
module tb_blinker_nios2_proc_oci_dct_packer;
   import blinker_nios2_proc_oci_dct_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   blinker_nios2_proc_oci_dct_packer_if bus();
   blinker_nios2_proc_oci_dct_packer dut (.clk(clk), .reset(reset), .bus(bus));

   int tests = 0;
   int fails = 0;

   // Model: pending codes, one held output buffer, phase 0=run 1=drain 2=ended.
   int          mq[$];
   bit          mov;
   logic [29:0] mob;
   int          moc;
   int          mph;
   bit          fresh;
   bit          last_acc;
   logic [29:0] got_buf[$];
   int          got_cnt[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("code_ready", bus.code_ready, 32'(!fresh && mph == 0 && mq.size() != 15));
      chk("dct_valid", bus.dct_valid, 32'(mov));
      chk("dct_buffer", bus.dct_buffer, 32'(mob));
      chk("dct_count", bus.dct_count, 32'(moc));
      chk("test_ending", bus.test_ending, 32'(mph == 1));
      chk("test_has_ended", bus.test_has_ended, 32'(mph == 2));
      if (bus.dct_valid === 1'b1) chk("count_nonzero", 32'(bus.dct_count != 0), 1);
   endtask

   task automatic drive(bit v, logic [1:0] d, bit r, bit te);
      bus.code_valid = v;
      bus.code_data  = d;
      bus.dct_ready  = r;
      bus.trace_end  = te;
   endtask

   task automatic step();
      int          nq[$];
      bit          nov, rdy, free;
      logic [29:0] nob;
      int          noc, nph;
      rdy  = !fresh && mph == 0 && mq.size() != 15;
      nq   = mq;
      last_acc = bus.code_valid && rdy;
      if (last_acc) nq.push_back(int'(bus.code_data));
      free = !mov || bus.dct_ready;
      nov  = mov && !bus.dct_ready;
      nob  = mob;
      noc  = moc;
      if (bus.dct_valid === 1'b1 && bus.dct_ready) begin
         got_buf.push_back(bus.dct_buffer);
         got_cnt.push_back(int'(bus.dct_count));
      end
      if (free && mq.size() > 0 && (mq.size() == 15 || mph == 1)) begin
         nov = 1'b1;
         nob = '0;
         foreach (mq[k]) nob = nob | (30'(mq[k]) << (2 * k));
         noc = mq.size();
         nq.delete();
      end
      nph = mph;
      if (mph == 0 && bus.trace_end) nph = 1;
      else if (mph == 1 && mq.size() == 0 && free) nph = 2;
      @(posedge clk);
      #1;
      mq = nq; mov = nov; mob = nob; moc = noc; mph = nph; fresh = 1'b0;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      mq.delete(); mov = 1'b0; mob = '0; moc = 0; mph = 0; fresh = 1'b1;
      got_buf.delete(); got_cnt.delete();
      compare_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all();
   endtask

   // code < 0 selects the k mod 4 pattern.
   task automatic feed(int cnt, int code, bit rdy);
      int n = 0;
      for (int i = 0; i < 100 && n < cnt; i++) begin
         drive(1'b1, (code < 0) ? 2'(n % 4) : 2'(code), rdy, 1'b0);
         step();
         if (last_acc) n++;
      end
      chk("feed_count", n, cnt);
      drive(1'b0, 2'b00, rdy, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);

      // Repeating 0,1,2,3 pattern, sink always ready.
      do_reset();
      feed(15, -1, 1'b1);
      chk("s1_ready_gap", bus.code_ready, 0);
      chk("s1_valid_wait", bus.dct_valid, 0);
      step();
      chk("s1_valid_up", bus.dct_valid, 1);
      chk("s1_ready_back", bus.code_ready, 1);
      step();
      chk("s1_valid_one_cycle", bus.dct_valid, 0);
      chk("s1_nbuf", got_buf.size(), 1);
      if (got_buf.size() >= 1) begin
         chk("s1_buf", got_buf[0], 32'h24E4E4E4);
         chk("s1_cnt", got_cnt[0], 15);
      end

      // 30 codes of 3 against a stalled sink, then release.
      do_reset();
      for (int c = 0; c < 40; c++) begin
         drive(1'b1, 2'b11, 1'b0, 1'b0);
         step();
      end
      chk("s2_stall_ready", bus.code_ready, 0);
      chk("s2_stall_valid", bus.dct_valid, 1);
      chk("s2_stall_buf", bus.dct_buffer, 32'h3FFFFFFF);
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      step();
      chk("s2_back_to_back", bus.dct_valid, 1);
      for (int c = 0; c < 5; c++) step();
      chk("s2_nbuf", got_buf.size(), 2);
      if (got_buf.size() == 2) begin
         chk("s2_buf1", got_buf[1], 32'h3FFFFFFF);
         chk("s2_cnt1", got_cnt[1], 15);
      end

      // Five codes then trace_end: partial flush and end of test.
      do_reset();
      feed(5, 1, 1'b1);
      drive(1'b0, 2'b00, 1'b1, 1'b1);
      step();
      chk("s3_ending", bus.test_ending, 1);
      for (int c = 0; c < 4; c++) step();
      chk("s3_ended", bus.test_has_ended, 1);
      drive(1'b1, 2'b01, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) step();
      chk("s3_no_accept", bus.code_ready, 0);
      chk("s3_nbuf", got_buf.size(), 1);
      if (got_buf.size() >= 1) begin
         chk("s3_buf", got_buf[0], 32'h155);
         chk("s3_cnt", got_cnt[0], 5);
      end

      // trace_end with nothing pending.
      do_reset();
      drive(1'b0, 2'b00, 1'b1, 1'b1);
      step();
      chk("s4_ending", bus.test_ending, 1);
      step();
      chk("s4_ending_drop", bus.test_ending, 0);
      chk("s4_ended", bus.test_has_ended, 1);
      step();
      chk("s4_nbuf", got_buf.size(), 0);

      // Code accepted in the same cycle as trace_end joins the flush.
      do_reset();
      feed(14, 3, 1'b1);
      drive(1'b1, 2'b10, 1'b1, 1'b1);
      step();
      chk("s5_accept", 32'(last_acc), 1);
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step();
      chk("s5_nbuf", got_buf.size(), 1);
      if (got_buf.size() >= 1) begin
         chk("s5_cnt", got_cnt[0], 15);
         chk("s5_slot14", 32'(got_buf[0][29:28]), 2);
      end

      // Reset mid-fill while a buffer is held.
      do_reset();
      feed(15, 1, 1'b0);
      step();
      feed(7, 2, 1'b0);
      chk("s6_held", bus.dct_valid, 1);
      do_reset();
      feed(15, 3, 1'b1);
      for (int c = 0; c < 3; c++) step();
      chk("s6_nbuf", got_buf.size(), 1);
      if (got_buf.size() >= 1) chk("s6_buf", got_buf[0], 32'h3FFFFFFF);

      // Randomized traffic with a late trace_end.
      for (int r = 0; r < 8; r++) begin
         int te_at = $urandom_range(60, 220);
         do_reset();
         for (int c = 0; c < 260; c++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), c >= te_at);
            step();
         end
         chk("rnd_ended", bus.test_has_ended, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
